// File: rtl/lsu_controller_pkg.sv
// Shared encodings for the load/store unit: RV32I opcodes, funct3 values,
// sequencer states and access-size decode.
package lsu_controller_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Unrecognised encodings fall back to a word access.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3, input logic is_store);
    lsu_size_e sz;
    sz = SZ_WORD;
    unique case (f3)
      3'b000:  sz = SZ_BYTE;
      3'b001:  sz = SZ_HALF;
      3'b100:  sz = is_store ? SZ_WORD : SZ_BYTE;
      3'b101:  sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// req/gnt/rvalid data-memory bus between the LSU (master) and memory (slave).
interface lsu_controller_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_controller_align.sv
// Byte-lane steering for the LSU: store strobes/lane replication, load
// byte/half selection with sign/zero extension, and misalignment detect.
module lsu_align
  import lsu_controller_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  lsu_size_e   size;
  logic        sgn;
  logic [31:0] rsh;

  always_comb begin
    size        = lsu_size(funct3, is_store);
    sgn         = ~funct3[2];
    rsh         = rdata >> {off, 3'b000};
    wstrb       = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    misaligned  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wstrb       = 4'(4'b0001 << off);
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sgn & rsh[7]}}, rsh[7:0]};
      end
      SZ_HALF: begin
        wstrb       = 4'(4'b0011 << off);
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sgn & rsh[15]}}, rsh[15:0]};
        misaligned  = off[0];
      end
      default: begin
        misaligned  = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer: stalls the core across one req/gnt/rvalid
// memory transaction and returns an aligned load result with lsu_valid.
module lsu_controller
  import lsu_controller_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               store,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic               lsu_valid,
  output logic [31:0]        load_data,
  output logic               access_fault,
  lsu_controller_if.master   mem
);

  lsu_state_e        state_q;
  logic [7:0]        cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic              stall_q;
  logic              lsu_valid_q;
  logic              fault_q;
  logic [31:0]       load_data_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic        req_in;
  logic        st_in;
  logic        in_idle;
  logic [2:0]  al_f3;
  logic        al_store;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misaligned;
  logic        accept;
  logic        timeout;

  // The aligner serves the incoming instruction while idle and the captured
  // one while a transaction is in flight.
  always_comb begin
    req_in   = load | store;
    st_in    = store & ~load;
    in_idle  = (state_q == LSU_IDLE);
    al_f3    = in_idle ? funct3     : f3_q;
    al_store = in_idle ? st_in      : we_q;
    al_off   = in_idle ? addr[1:0]  : off_q;
    accept   = in_idle & req_in & ~al_misaligned;
    timeout  = (cnt_q == 8'(TIMEOUT_CYC - 1));
  end

  lsu_align u_align (
    .funct3      (al_f3),
    .is_store    (al_store),
    .off         (al_off),
    .wdata       (wdata),
    .rdata       (mem.rdata),
    .wstrb       (al_wstrb),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      stall_q     <= 1'b0;
      lsu_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      lsu_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      unique case (state_q)
        LSU_IDLE: begin
          cnt_q <= '0;
          if (req_in) begin
            if (al_misaligned) begin
              fault_q <= 1'b1;
            end else begin
              state_q     <= LSU_REQ;
              stall_q     <= 1'b1;
              mem_req_q   <= 1'b1;
              f3_q        <= funct3;
              off_q       <= addr[1:0];
              we_q        <= st_in;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= st_in ? al_wdata : '0;
              mem_wstrb_q <= st_in ? al_wstrb : '0;
            end
          end
        end
        LSU_REQ, LSU_WAIT: begin
          // Completion outranks the timeout on the final cycle.
          if (mem.rvalid && (state_q == LSU_WAIT || mem.gnt)) begin
            state_q     <= LSU_DONE;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            lsu_valid_q <= 1'b1;
            load_data_q <= we_q ? '0 : al_rdata;
            cnt_q       <= '0;
          end else if (timeout) begin
            state_q   <= LSU_IDLE;
            stall_q   <= 1'b0;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            cnt_q     <= '0;
          end else begin
            if (state_q == LSU_REQ && mem.gnt) begin
              state_q   <= LSU_WAIT;
              mem_req_q <= 1'b0;
            end
            cnt_q <= cnt_q + 8'd1;
          end
        end
        LSU_DONE: begin
          state_q <= LSU_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign stall        = stall_q | accept;
  assign lsu_valid    = lsu_valid_q;
  assign load_data    = load_data_q;
  assign access_fault = fault_q;
  assign mem.req      = mem_req_q;
  assign mem.we       = we_q;
  assign mem.addr     = mem_addr_q;
  assign mem.wdata    = mem_wdata_q;
  assign mem.wstrb    = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed-vector bench for lsu_controller with a hand-driven memory responder.
module tb_lsu_controller;
  import lsu_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        lsu_valid;
  logic [31:0] load_data;
  logic        access_fault;

  int unsigned n_vec;
  int unsigned n_err;

  lsu_controller_if #(.ADDR_W(32)) mem_if ();

  lsu_controller #(.ADDR_W(32), .TIMEOUT_CYC(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .store        (store),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .lsu_valid    (lsu_valid),
    .load_data    (load_data),
    .access_fault (access_fault),
    .mem          (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Zero-wait transaction; the decoder keeps the instruction asserted until lsu_valid.
  task automatic txn_zw(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] estrb, input logic [31:0] ewd, input logic [31:0] eld);
    logic [31:0] ea;
    ea = {a[31:2], 2'b00};
    @(negedge clk);
    load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
    #1 check_vec({tag, "_stall_acc"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    check_vec({tag, "_req"},   {31'b0, mem_if.req}, 32'd1);
    check_vec({tag, "_addr"},  mem_if.addr, ea);
    check_vec({tag, "_we"},    {31'b0, mem_if.we}, {31'b0, st & ~ld});
    check_vec({tag, "_wstrb"}, {28'b0, mem_if.wstrb}, {28'b0, estrb});
    check_vec({tag, "_wdata"}, mem_if.wdata, ewd);
    check_vec({tag, "_vld_early"}, {31'b0, lsu_valid}, 32'd0);
    mem_if.gnt = 1'b1; mem_if.rvalid = 1'b1; mem_if.rdata = rd;
    @(negedge clk);
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
    check_vec({tag, "_vld"},      {31'b0, lsu_valid}, 32'd1);
    check_vec({tag, "_ldata"},    load_data, eld);
    check_vec({tag, "_stall_dn"}, {31'b0, stall}, 32'd0);
    check_vec({tag, "_req_dn"},   {31'b0, mem_if.req}, 32'd0);
    load = 1'b0; store = 1'b0;
    @(negedge clk);
    check_vec({tag, "_vld_end"}, {31'b0, lsu_valid}, 32'd0);
  endtask

  task automatic misal(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a);
    @(negedge clk);
    load = ld; store = st; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
    #1 check_vec({tag, "_stall"}, {31'b0, stall}, 32'd0);
    @(negedge clk);
    check_vec({tag, "_fault"}, {31'b0, access_fault}, 32'd1);
    check_vec({tag, "_noreq"}, {31'b0, mem_if.req}, 32'd0);
    load = 1'b0; store = 1'b0;
    @(negedge clk);
    check_vec({tag, "_fault_end"}, {31'b0, access_fault}, 32'd0);
    check_vec({tag, "_noreq_end"}, {31'b0, mem_if.req}, 32'd0);
  endtask

  initial begin
    logic bad;
    n_vec = 0; n_err = 0;
    rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
    #2;
    check_vec("rst_stall", {31'b0, stall}, 32'd0);
    check_vec("rst_vld",   {31'b0, lsu_valid}, 32'd0);
    check_vec("rst_ldata", load_data, 32'h0);
    check_vec("rst_fault", {31'b0, access_fault}, 32'd0);
    check_vec("rst_req",   {31'b0, mem_if.req}, 32'd0);
    check_vec("rst_addr",  mem_if.addr, 32'h0);
    check_vec("rst_wstrb", {28'b0, mem_if.wstrb}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    txn_zw("sw",      1'b0, 1'b1, FUNCT3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0);
    txn_zw("lb",      1'b1, 1'b0, FUNCT3_LB,  32'h103, 32'h0,        32'h80FFFFFF, 4'b0000, 32'h0,        32'hFFFFFF80);
    txn_zw("lbu",     1'b1, 1'b0, FUNCT3_LBU, 32'h103, 32'h0,        32'h80FFFFFF, 4'b0000, 32'h0,        32'h00000080);
    txn_zw("lb_pos",  1'b1, 1'b0, FUNCT3_LB,  32'h100, 32'h0,        32'h80FFFF7F, 4'b0000, 32'h0,        32'h0000007F);
    txn_zw("lh",      1'b1, 1'b0, FUNCT3_LH,  32'h102, 32'h0,        32'h80017F00, 4'b0000, 32'h0,        32'hFFFF8001);
    txn_zw("lhu",     1'b1, 1'b0, FUNCT3_LHU, 32'h102, 32'h0,        32'h80017F00, 4'b0000, 32'h0,        32'h00008001);
    txn_zw("sh_hi",   1'b0, 1'b1, FUNCT3_SH,  32'h102, 32'h00001234, 32'h0,        4'b1100, 32'h12341234, 32'h0);
    txn_zw("sh_lo",   1'b0, 1'b1, FUNCT3_SH,  32'h100, 32'hCAFE5678, 32'h0,        4'b0011, 32'h56785678, 32'h0);
    txn_zw("sb",      1'b0, 1'b1, FUNCT3_SB,  32'h101, 32'h000000AB, 32'h0,        4'b0010, 32'hABABABAB, 32'h0);
    txn_zw("f3_unk",  1'b1, 1'b0, 3'b111,     32'h108, 32'h0,        32'h0BADF00D, 4'b0000, 32'h0,        32'h0BADF00D);
    txn_zw("ld_st",   1'b1, 1'b1, FUNCT3_LW,  32'h10C, 32'h55555555, 32'h13579BDF, 4'b0000, 32'h0,        32'h13579BDF);

    misal("lh_mis", 1'b1, 1'b0, FUNCT3_LH, 32'h101);
    misal("sw_mis", 1'b0, 1'b1, FUNCT3_SW, 32'h102);
    misal("lw_mis", 1'b1, 1'b0, FUNCT3_LW, 32'h203);

    // Slow memory: gnt after 3 request cycles, rvalid 5 cycles later.
    @(negedge clk);
    load = 1'b1; funct3 = FUNCT3_LW; addr = 32'h200;
    @(negedge clk);
    load = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h200 || stall !== 1'b1 || lsu_valid !== 1'b0) bad = 1'b1;
    end
    check_vec("slow_req_hold", {31'b0, bad}, 32'd0);
    mem_if.gnt = 1'b1;
    @(negedge clk);
    mem_if.gnt = 1'b0;
    check_vec("slow_wait_req", {31'b0, mem_if.req}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (stall !== 1'b1 || lsu_valid !== 1'b0 || mem_if.req !== 1'b0) bad = 1'b1;
    end
    check_vec("slow_wait_stall", {31'b0, bad}, 32'd0);
    @(negedge clk);
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
    check_vec("slow_vld",   {31'b0, lsu_valid}, 32'd1);
    check_vec("slow_ldata", load_data, 32'hCAFEF00D);
    check_vec("slow_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check_vec("slow_vld_once", {31'b0, lsu_valid}, 32'd0);

    // Timeout: no gnt for 255 cycles in REQ.
    @(negedge clk);
    load = 1'b1; funct3 = FUNCT3_LW; addr = 32'h300;
    @(negedge clk);
    load = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_if.req !== 1'b1 || stall !== 1'b1 || access_fault !== 1'b0) bad = 1'b1;
    end
    check_vec("tmo_pending", {31'b0, bad}, 32'd0);
    @(negedge clk);
    check_vec("tmo_fault", {31'b0, access_fault}, 32'd1);
    check_vec("tmo_req",   {31'b0, mem_if.req}, 32'd0);
    check_vec("tmo_stall", {31'b0, stall}, 32'd0);
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'h77777777;
    @(negedge clk);
    mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
    check_vec("tmo_late_vld",   {31'b0, lsu_valid}, 32'd0);
    check_vec("tmo_fault_once", {31'b0, access_fault}, 32'd0);
    @(negedge clk);
    check_vec("tmo_late_vld2",  {31'b0, lsu_valid}, 32'd0);
    check_vec("tmo_late_stall", {31'b0, stall}, 32'd0);

    // Reset while in REQ drops mem_req at once.
    @(negedge clk);
    load = 1'b1; funct3 = FUNCT3_LW; addr = 32'h3F0;
    @(negedge clk);
    load = 1'b0;
    check_vec("rreq_req_pre", {31'b0, mem_if.req}, 32'd1);
    #1 rst = 1'b1;
    #1 check_vec("rreq_req", {31'b0, mem_if.req}, 32'd0);
    check_vec("rreq_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in WAIT.
    @(negedge clk);
    load = 1'b1; funct3 = FUNCT3_LW; addr = 32'h400;
    @(negedge clk);
    load = 1'b0;
    mem_if.gnt = 1'b1;
    @(negedge clk);
    mem_if.gnt = 1'b0;
    check_vec("rwait_stall_pre", {31'b0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1 check_vec("rwait_stall", {31'b0, stall}, 32'd0);
    check_vec("rwait_req", {31'b0, mem_if.req}, 32'd0);
    check_vec("rwait_vld", {31'b0, lsu_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn_zw("post_rst", 1'b1, 1'b0, FUNCT3_LW, 32'h404, 32'h0, 32'h11223344, 4'b0000, 32'h0, 32'h11223344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
